// File: rtl/flag_register_unit_if.sv
// Bus between the ALU/sequencer side and the flag register unit.
// master drives the ALU result and stack controls; slave returns live flags and stack status.
interface flag_register_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic             upd_zs;
  logic             upd_c;
  logic             push;
  logic             pop;
  logic             fZero;
  logic             fSign;
  logic             fCarry;
  logic             stack_empty;
  logic             stack_full;
  logic             stack_ovf;
  logic             stack_unf;

  modport master (
    output alu_result, alu_carry, upd_zs, upd_c, push, pop,
    input  fZero, fSign, fCarry, stack_empty, stack_full, stack_ovf, stack_unf
  );

  modport slave (
    input  alu_result, alu_carry, upd_zs, upd_c, push, pop,
    output fZero, fSign, fCarry, stack_empty, stack_full, stack_ovf, stack_unf
  );
endinterface

// File: rtl/flag_register_unit.sv
// Live condition flags {Z,S,C} with a small save/restore stack for call/return.
// All outputs are registered; ALU updates take priority over stack restores per field.
module flag_register_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  flag_register_unit_if.slave  bus
);
  localparam int unsigned IW = $clog2(STACK_DEPTH);
  localparam int unsigned CW = IW + 1;

  // Flag vector layout: [2]=Z, [1]=S, [0]=C
  logic [2:0]    flags_q, flags_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic [2:0]    stack_q [STACK_DEPTH];
  logic [2:0]    stack_d [STACK_DEPTH];

  logic          is_empty;
  logic          is_full;
  logic [IW-1:0] top_idx;
  logic [2:0]    top_flags;
  logic          wr_en;
  logic [IW-1:0] wr_idx;

  assign is_empty  = (count_q == '0);
  assign is_full   = (count_q == CW'(STACK_DEPTH));
  assign top_idx   = IW'(count_q - CW'(1));
  assign top_flags = stack_q[top_idx];

  // Next-state for live flags, count, sticky errors and stack write control
  always_comb begin
    flags_d = flags_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    wr_en   = 1'b0;
    wr_idx  = count_q[IW-1:0];

    // Stack operation first; simultaneous push+pop on a non-empty stack
    // swaps live flags with the top entry and leaves count alone.
    if (bus.push && bus.pop && !is_empty) begin
      wr_en   = 1'b1;
      wr_idx  = top_idx;
      flags_d = top_flags;
    end else if (bus.push) begin
      if (!is_full) begin
        wr_en   = 1'b1;
        count_d = count_q + CW'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end else if (bus.pop) begin
      if (!is_empty) begin
        flags_d = top_flags;
        count_d = count_q - CW'(1);
      end else begin
        unf_d = 1'b1;
      end
    end

    // ALU update overrides any restored value for the selected fields
    if (bus.upd_zs) begin
      flags_d[2] = (bus.alu_result == '0);
      flags_d[1] = bus.alu_result[$bits(bus.alu_result)-1];
    end
    if (bus.upd_c) begin
      flags_d[0] = bus.alu_carry;
    end
  end

  // Stack array next-state: the pushed entry is always the pre-update live flags
  always_comb begin
    stack_d = stack_q;
    if (wr_en) begin
      stack_d[wr_idx] = flags_q;
    end
  end

  // Control and flag registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack storage; contents are don't-care after reset since count gates access
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

  assign bus.fZero       = flags_q[2];
  assign bus.fSign       = flags_q[1];
  assign bus.fCarry      = flags_q[0];
  assign bus.stack_empty = is_empty;
  assign bus.stack_full  = is_full;
  assign bus.stack_ovf   = ovf_q;
  assign bus.stack_unf   = unf_q;
endmodule

// File: tb/tb_flag_register_unit.sv
// Directed vector bench for flag_register_unit (WIDTH=32, STACK_DEPTH=4).
// Expected outputs packed as {Z,S,C,empty,full,ovf,unf}.
module tb_flag_register_unit;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  flag_register_unit_if #(.WIDTH(32)) bus ();

  flag_register_unit #(
    .WIDTH       (32),
    .STACK_DEPTH (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        r;
    logic [31:0] res;
    logic        cy;
    logic        uzs;
    logic        uc;
    logic        pu;
    logic        po;
    logic [6:0]  exp;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(logic r, logic [31:0] res, logic cy, logic uzs,
                              logic uc, logic pu, logic po, logic [6:0] exp);
    vec_t v;
    v.r = r; v.res = res; v.cy = cy; v.uzs = uzs; v.uc = uc;
    v.pu = pu; v.po = po; v.exp = exp;
    return v;
  endfunction

  // Drive one cycle of inputs, then compare all outputs just after the edge
  task automatic step(input string name, input vec_t v);
    logic [6:0] act;
    rst            = v.r;
    bus.alu_result = v.res;
    bus.alu_carry  = v.cy;
    bus.upd_zs     = v.uzs;
    bus.upd_c      = v.uc;
    bus.push       = v.pu;
    bus.pop        = v.po;
    @(posedge clk);
    #1;
    act = {bus.fZero, bus.fSign, bus.fCarry, bus.stack_empty,
           bus.stack_full, bus.stack_ovf, bus.stack_unf};
    n_checks++;
    if (act !== v.exp) begin
      n_fail++;
      $display("FAIL %s: got ZSC_EFOU=%b required %b", name, act, v.exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.alu_result = '0; bus.alu_carry = 1'b0; bus.upd_zs = 1'b0;
    bus.upd_c = 1'b0; bus.push = 1'b0; bus.pop = 1'b0;

    //                r   result        cy    uzs   uc    push  pop   Z S C E F O U
    vecs.push_back(mk(1, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b000_1000));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 32'h0,      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b000_1000));
    vecs.push_back(mk(0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b100_1000));
    vecs.push_back(mk(0, 32'h8000_0000,1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b010_1000));
    vecs.push_back(mk(0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'b011_1000));
    vecs.push_back(mk(0, 32'h0001_0000,1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b001_1000));
    // save {1,0,1}, clobber, restore
    vecs.push_back(mk(0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b101_1000));
    vecs.push_back(mk(0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'b101_0000));
    vecs.push_back(mk(0, 32'h8000_0000,1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 7'b010_0000));
    vecs.push_back(mk(0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'b101_1000));
    // fill: entries {101},{010},{011},{101}; each push saves pre-update flags
    vecs.push_back(mk(0, 32'h8000_0000,1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 7'b010_0000));
    vecs.push_back(mk(0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 7'b011_0000));
    vecs.push_back(mk(0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 7'b101_0000));
    vecs.push_back(mk(0, 32'h5,        1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 7'b000_0100));
    vecs.push_back(mk(0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'b000_0110));
    // drain in LIFO order
    vecs.push_back(mk(0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'b101_0010));
    vecs.push_back(mk(0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'b011_0010));
    vecs.push_back(mk(0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'b010_0010));
    vecs.push_back(mk(0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'b101_1010));
    // underflow: updates still apply, Z/S held, sticky
    vecs.push_back(mk(0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 7'b100_1011));
    vecs.push_back(mk(0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 7'b101_1011));
    vecs.push_back(mk(0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b101_1011));
    // rst overrides push and update in the same cycle
    vecs.push_back(mk(1, 32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 7'b000_1000));
    // push+pop on empty acts as push only, no underflow
    vecs.push_back(mk(0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7'b000_0000));
    vecs.push_back(mk(0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'b000_1000));
    // pop with partial update: Z/S from ALU, C from stack top
    vecs.push_back(mk(0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'b001_1000));
    vecs.push_back(mk(0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'b001_0000));
    vecs.push_back(mk(0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 7'b100_0000));
    vecs.push_back(mk(0, 32'h8000_0000,1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 7'b011_1000));

    for (int i = 0; i < vecs.size(); i++)
      step($sformatf("vec%0d", i), vecs[i]);

    // Swap: top {1,0,0}, live {0,0,1}, push+pop with upd_zs result=5
    step("swap_rst",    mk(1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b000_1000));
    step("swap_setz",   mk(0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b100_1000));
    step("swap_push",   mk(0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'b100_0000));
    step("swap_live",   mk(0, 32'h1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 7'b001_0000));
    step("swap_do",     mk(0, 32'h5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 7'b000_0000));
    step("swap_top",    mk(0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'b001_1000));

    // Swap with no update: live takes old top entirely, count held
    step("swap2_push",  mk(0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'b001_0000));
    step("swap2_live",  mk(0, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 7'b010_0000));
    step("swap2_do",    mk(0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7'b001_0000));
    step("swap2_top",   mk(0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'b010_1000));

    // Reset mid-sequence discards entries; next pop underflows
    step("mid_push1",   mk(0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'b010_0000));
    step("mid_push2",   mk(0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'b010_0000));
    step("mid_rst",     mk(1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b000_1000));
    step("mid_pop",     mk(0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'b000_1001));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
